// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic ops plus iterative MULTU/DIVU into HI/LO.
// Define ALU_DIV_EN to build the restoring divider; otherwise DIVU flags dz.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] num_1,
   input  logic [WIDTH-1:0] num_2,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               div_q, div_d;

   logic               accept;
   logic [WIDTH-1:0]   res;
   logic [WIDTH:0]     msum;
   logic [WIDTH:0]     dtry;

   assign accept = start && !busy_q;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = dz_q;
      p_d      = p_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      res      = '0;
      msum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? b_q : '0)};
      dtry     = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]} - {1'b0, b_q};

      unique case (state_q)
         CALC: begin
`ifdef ALU_DIV_EN
            if (div_q) begin
               // restoring step: keep the trial remainder only if it did not borrow
               if (!dtry[WIDTH]) p_d = {dtry[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
               else              p_d = {p_q[2*WIDTH-2:0], 1'b0};
            end else begin
               p_d = {msum, p_q[WIDTH-1:1]};
            end
`else
            p_d = {msum, p_q[WIDTH-1:1]};
`endif
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FIN: begin
            hi_d    = p_q[2*WIDTH-1:WIDTH];
            lo_d    = p_q[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         dz_d = 1'b0;
         unique case (op)
            3'b110: begin
               p_d     = {{WIDTH{1'b0}}, num_2};
               b_d     = num_1;
               cnt_d   = '0;
               div_d   = 1'b0;
               state_d = CALC;
            end
            3'b111: begin
`ifdef ALU_DIV_EN
               if (num_2 == '0) begin
                  p_d     = {num_1, {WIDTH{1'b1}}};
                  dz_d    = 1'b1;
                  state_d = FIN;
               end else begin
                  p_d     = {{WIDTH{1'b0}}, num_1};
                  b_d     = num_2;
                  cnt_d   = '0;
                  div_d   = 1'b1;
                  state_d = CALC;
               end
`else
               hi_d    = '0;
               lo_d    = '0;
               dz_d    = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
`endif
            end
            default: begin
               unique case (op)
                  3'b000:  res = num_1 + num_2;
                  3'b001:  res = num_1 - num_2;
                  3'b010:  res = num_1 | num_2;
                  3'b011:  res = num_1 & num_2;
                  3'b100:  res = {{(WIDTH-1){1'b0}}, $signed(num_1) < $signed(num_2)};
                  default: res = {{(WIDTH-1){1'b0}}, num_1 < num_2};
               endcase
               result_d = res;
               zero_d   = (res == '0);
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         endcase
      end

      // divide-by-zero passes through FIN without ever raising busy
      busy_d = (state_d == CALC) || (state_d == FIN && state_q == CALC);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         p_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         div_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         p_q      <= p_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
      end
   end

   assign result = result_q;
   assign zero   = zero_q;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign dz     = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): vector table plus multi-cycle sequences.
// DIVU expectations follow whether ALU_DIV_EN is defined.
module tb_alu_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = '0;
   logic [W-1:0] num_1 = '0;
   logic [W-1:0] num_2 = '0;
   logic [W-1:0] result, hi, lo;
   logic         zero, busy, done, dz;

   int total = 0;
   int bad = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .num_1(num_1), .num_2(num_2), .result(result), .zero(zero),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         z;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      op    = o;
      num_1 = a;
      num_2 = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      num_1 = '1;
      num_2 = '1;
   endtask

   // advances until busy drops; returns number of busy cycles seen
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(posedge clk);
         #1;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL timeout: busy stuck after %0d cycles", n);
      end
   endtask

   int n;

   initial begin
      vt[0] = '{3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1};
      vt[1] = '{3'b000, 32'd5, 32'd7, 32'd12, 1'b0};
      vt[2] = '{3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0};
      vt[3] = '{3'b001, 32'd9, 32'd9, 32'h0, 1'b1};
      vt[4] = '{3'b010, 32'hF0, 32'h0F, 32'hFF, 1'b0};
      vt[5] = '{3'b011, 32'hF0, 32'h3C, 32'h30, 1'b0};
      vt[6] = '{3'b100, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0};
      vt[7] = '{3'b101, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1};
      vt[8] = '{3'b100, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1};
      vt[9] = '{3'b101, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0};

      #12;
      chk("reset_outs", {result, hi}, 64'h0);
      chk("reset_lo", {32'h0, lo}, 64'h0);
      chk("reset_flags", {zero, busy, done, dz}, 4'b0000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(vt[0].op, vt[0].a, vt[0].b);
      chk("addu_wrap_res", result, vt[0].res);
      chk("addu_wrap_zero_done", {zero, done}, 2'b11);
      chk("addu_wrap_hilo", {hi, lo}, 64'h0);
      @(posedge clk);
      #1;
      chk("done_one_cycle", done, 1'b0);

      // back-to-back single-cycle ops keep done high every cycle
      for (int i = 1; i < 10; i++) begin
         issue(vt[i].op, vt[i].a, vt[i].b);
         chk($sformatf("vec%0d_res", i), result, vt[i].res);
         chk($sformatf("vec%0d_zero", i), zero, vt[i].z);
         chk($sformatf("vec%0d_done", i), {done, busy}, 2'b10);
      end
      @(posedge clk);
      #1;

      issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mul_busy_e0", {busy, done}, 2'b10);
      n = 0;
      while (busy && n < 200) begin
         n++;
         if (n == 5) begin
            start = 1'b1;
            op    = 3'b000;
            num_1 = 32'd1;
            num_2 = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk("mul_busy_cycles", n, 33);
      chk("mul_done", done, 1'b1);
      chk("mul_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      chk("mul_result_kept", {result, 31'h0, zero}, {32'h1, 32'h0});
      @(posedge clk);
      #1;
      chk("mul_done_pulse", {done, busy}, 2'b00);

      issue(3'b110, 32'h1234_5678, 32'h10);
      wait_idle(n);
      chk("mul2_hilo", {hi, lo}, 64'h0000_0001_2345_6780);
      chk("mul2_done", done, 1'b1);

`ifdef ALU_DIV_EN
      issue(3'b111, 32'd100, 32'd7);
      wait_idle(n);
      chk("div_cycles", n, 33);
      chk("div_hilo", {hi, lo}, {32'd2, 32'd14});
      chk("div_done_dz", {done, dz}, 2'b10);

      issue(3'b111, 32'd5, 32'd0);
      chk("dz_e1", {busy, done}, 2'b00);
      @(posedge clk);
      #1;
      chk("dz_done", {busy, done, dz}, 3'b011);
      chk("dz_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
      @(posedge clk);
      #1;
      chk("dz_sticky", {busy, done, dz}, 3'b001);
`else
      issue(3'b111, 32'd100, 32'd7);
      chk("nodiv_done", {busy, done, dz}, 3'b011);
      chk("nodiv_hilo", {hi, lo}, 64'h0);
      @(posedge clk);
      #1;
      chk("nodiv_dz_sticky", {done, dz}, 2'b01);
`endif

      issue(3'b110, 32'd3, 32'd4);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_outs", {result, hi}, 64'h0);
      chk("abort_lo", {32'h0, lo}, 64'h0);
      chk("abort_flags", {zero, busy, done, dz}, 4'b0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) n++;
      end
      chk("abort_no_done", n, 0);

      issue(3'b010, 32'hF0, 32'h0F);
      chk("or_after_reset", result, 32'hFF);
      chk("or_done", {done, zero}, 2'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU: the successor to the single-cycle datapath ALU. It adds a WIDTH parameter, a start/busy/done handshake, registered outputs and iterative unsigned multiply and divide into HI/LO registers. It sits in the execute stage, and the controller stalls the pipeline while busy is high.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥4).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  opcode: 000 ADDU, 001 SUBU, 010 OR, 011 AND, 100 SLT (signed), 101 SLTU, 110 MULTU, 111 DIVU.
- num_1  in  WIDTH  operand A, captured at acceptance.
- num_2  in  WIDTH  operand B, captured at acceptance.
- result  out  WIDTH  registered result of single-cycle ops; holds until the next single-cycle op.
- zero  out  1  registered, result==0; updated with result.
- hi  out  WIDTH  MULTU product upper half / DIVU remainder.
- lo  out  WIDTH  MULTU product lower half / DIVU quotient.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse when the accepted op completes.
- dz  out  1  sticky until next acceptance: last DIVU had num_2=0.

## Operation
- Reset: all outputs 0, state IDLE, internal counters/shift registers 0.
- Acceptance: start=1 and busy=0 at a rising edge. The op and operands are latched; start while busy=1 is ignored, not queued.
- Single-cycle ops (000–101): computed modulo 2^WIDTH; SLT/SLTU give 1 or 0 in bit 0. result and zero are written at the acceptance edge. hi/lo are unchanged.
- MULTU: radix-2 shift-add over WIDTH iterations; {hi,lo} = num_1*num_2, full 2·WIDTH-bit unsigned product.
- DIVU: restoring division over WIDTH iterations; lo = quotient, hi = remainder.
- DIVU with num_2=0: no iteration. lo = all ones, hi = num_1, dz=1, done on the next edge.
- For MULTU/DIVU, result and zero are unchanged; hi/lo update only at completion.
- FSM states:
  - IDLE: accept a single-cycle op → stay IDLE with done=1 next cycle. Accept MULTU/DIVU → CALC (busy=1), or → FIN on divide-by-zero.
  - CALC: iteration counter runs 0..WIDTH-1. After the last iteration → FIN.
  - FIN: write hi/lo, done=1, busy=0 → IDLE.
- Reset asserted mid-operation aborts immediately. All state is cleared and no done pulse is issued.

## Timing
- Edge E0 = acceptance edge.
- Single-cycle op: result/zero/done valid in the cycle after E0 (latency 1). done lasts exactly one cycle.
- MULTU/DIVU:
  - busy=1 from E0 to E(WIDTH+1).
  - hi/lo/done valid in the cycle after E(WIDTH+1), i.e. latency WIDTH+1 = 33 for WIDTH=32.
- DIVU by zero: busy=0 throughout, done after E1 (latency 2).
- Back-to-back:
  - A new start is accepted in any cycle with busy=0, including the done cycle.
  - done of the old op and acceptance of the new op may coincide.
  - A single-cycle op accepted each cycle yields done continuously high.
- Operand inputs may change freely after E0.

## Configuration
- ALU_DIV_EN defined: DIVU is implemented as above.
- ALU_DIV_EN undefined: the divider datapath is removed. DIVU completes like a single-cycle op (done after E0) with hi=lo=0 and dz=1, flagging an unsupported op. MULTU is unaffected.

## Test plan
- Reset, then ADDU 0xFFFFFFFF+1 → one cycle later result=0, zero=1, done=1 for one cycle, hi/lo=0.
- SLT num_1=0xFFFFFFFF, num_2=1 → result=1. SLTU with the same operands → result=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → busy 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done one cycle. A start pulsed mid-operation is ignored.
- DIVU 100÷7 → lo=14, hi=2, dz=0. DIVU 5÷0 → lo=0xFFFFFFFF, hi=5, dz=1, done after 2 cycles, busy never set.
- MULTU 3×4 with rst_n pulled low at iteration 10 → all outputs 0, no done pulse. After release, ORI-style OR 0xF0|0x0F → result=0xFF.
- Build without ALU_DIV_EN: DIVU 100÷7 → done next cycle, hi=lo=0, dz=1.
